// File: rtl/car_call_scheduler.sv
// rtl/car_call_scheduler.sv - SCAN call scheduler for one elevator car
//
// Collects floor calls, picks the next floor with a SCAN sweep, issues the
// go command to car_indicator, waits for car_done, then clears the served call
// and picks again. A 1 s tick watchdog latches a sticky fault if a trip stalls.
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous reset, active low
//   call_valid  in   1-cycle strobe, registers call_floor
//   call_floor  in   requested floor (dropped if >= NUM_FLOORS)
//   location    in   current car floor
//   car_done    in   1-cycle pulse, car at dest and door cycle finished
//   tick_1s     in   1 s pulse from the seconds counter
//   dest        out  target floor
//   dest_valid  out  go command, high in DISPATCH and TRAVEL
//   tmr_clr     out  1-cycle timer clear, high in DISPATCH
//   dir_up      out  sweep direction, 1 = up
//   pending     out  bitmask of outstanding calls
//   fault       out  sticky trip-timeout flag
module car_call_scheduler #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int TIMEOUT_S  = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    location,
  input  logic                  car_done,
  input  logic                  tick_1s,
  output logic [FLOOR_W-1:0]    dest,
  output logic                  dest_valid,
  output logic                  tmr_clr,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault
);

  localparam int WD_W = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_TRAVEL   = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_dest;
  logic                  r_dir_up;
  logic [WD_W-1:0]       r_wd;
  logic                  r_dest_valid;
  logic                  r_tmr_clr;
  logic                  r_fault;

  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [WD_W-1:0]       w_wd_nxt;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_found_fwd;
  logic                  w_found_rev;
  logic [FLOOR_W-1:0]    w_fwd;
  logic [FLOOR_W-1:0]    w_rev;
  logic [FLOOR_W-1:0]    w_sel;
  logic                  w_dir_nxt;
  logic                  w_dest_valid_nxt;
  logic                  w_tmr_clr_nxt;
  logic                  w_fault_nxt;

  // Target search. "fwd" is the nearest call ahead of the car in the current
  // sweep direction (the car's own floor counts as ahead); "rev" is the
  // nearest call behind it, used only when nothing lies ahead. The loop order
  // makes the last match the nearest one.
  always_comb begin
    w_found_fwd = 1'b0;
    w_found_rev = 1'b0;
    w_fwd       = '0;
    w_rev       = '0;
    if (r_dir_up) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (r_pending[i] && (i >= int'(location))) begin
          w_found_fwd = 1'b1;
          w_fwd       = FLOOR_W'(i);
        end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (r_pending[i] && (i < int'(location))) begin
          w_found_rev = 1'b1;
          w_rev       = FLOOR_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (r_pending[i] && (i <= int'(location))) begin
          w_found_fwd = 1'b1;
          w_fwd       = FLOOR_W'(i);
        end
      end
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (r_pending[i] && (i > int'(location))) begin
          w_found_rev = 1'b1;
          w_rev       = FLOOR_W'(i);
        end
      end
    end
    w_sel     = w_found_fwd ? w_fwd : w_rev;
    w_dir_nxt = w_found_fwd ? r_dir_up : ~r_dir_up;
  end

  // Call bookkeeping. A new call is OR-ed in after the clear, so a call for
  // dest landing on the car_done edge keeps the floor pending.
  always_comb begin
    w_set = '0;
    if (call_valid && (int'(call_floor) < NUM_FLOORS)) begin
      w_set = NUM_FLOORS'(1) << call_floor;
    end
    w_done = (r_state == S_TRAVEL) && car_done;
    w_clr  = w_done ? (NUM_FLOORS'(1) << r_dest) : '0;
  end

  // Watchdog: cleared in DISPATCH, counts ticks in TRAVEL, saturates.
  always_comb begin
    w_wd_nxt = r_wd;
    if (r_state == S_DISPATCH) begin
      w_wd_nxt = '0;
    end else if ((r_state == S_TRAVEL) && tick_1s && (r_wd != WD_W'(TIMEOUT_S))) begin
      w_wd_nxt = r_wd + WD_W'(1);
    end
    w_timeout = (r_state == S_TRAVEL) && (w_wd_nxt == WD_W'(TIMEOUT_S));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (|r_pending) w_state_nxt = S_DISPATCH;
      S_DISPATCH: w_state_nxt = S_TRAVEL;
      S_TRAVEL: begin
        // car_done has priority over a timeout on the same edge
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_FAULT:    w_state_nxt = S_FAULT;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_dest_valid_nxt = (w_state_nxt == S_DISPATCH) || (w_state_nxt == S_TRAVEL);
    w_tmr_clr_nxt    = (w_state_nxt == S_DISPATCH);
    w_fault_nxt      = r_fault || (w_state_nxt == S_FAULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending    <= '0;
      r_dest       <= '0;
      r_dir_up     <= 1'b1;
      r_wd         <= '0;
      r_dest_valid <= 1'b0;
      r_tmr_clr    <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_pending    <= (r_pending & ~w_clr) | w_set;
      r_wd         <= w_wd_nxt;
      r_dest_valid <= w_dest_valid_nxt;
      r_tmr_clr    <= w_tmr_clr_nxt;
      r_fault      <= w_fault_nxt;
      if ((r_state == S_IDLE) && (|r_pending)) begin
        r_dest   <= w_sel;
        r_dir_up <= w_dir_nxt;
      end
    end
  end

  assign dest       = r_dest;
  assign dest_valid = r_dest_valid;
  assign tmr_clr    = r_tmr_clr;
  assign dir_up     = r_dir_up;
  assign pending    = r_pending;
  assign fault      = r_fault;

endmodule

// File: tb/tb_car_call_scheduler.sv
// tb/tb_car_call_scheduler.sv - self-checking bench for car_call_scheduler
module tb_car_call_scheduler;

  logic       clk;
  logic       resetn;
  logic       call_valid;
  logic [2:0] call_floor;
  logic [2:0] location;
  logic       car_done;
  logic       tick_1s;
  logic [2:0] dest;
  logic       dest_valid;
  logic       tmr_clr;
  logic       dir_up;
  logic [7:0] pending;
  logic       fault;

  logic       c6_valid;
  logic [2:0] c6_floor;
  logic [2:0] loc6;
  logic       done6;
  logic       tick6;
  logic [2:0] dest6;
  logic       dv6;
  logic       clr6;
  logic       dir6;
  logic [5:0] pending6;
  logic       fault6;

  int tests_run = 0;
  int tests_failed = 0;

  bit m_pend[8];
  bit m_dir;

  car_call_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3), .TIMEOUT_S(15)) dut (
    .clk(clk), .resetn(resetn), .call_valid(call_valid), .call_floor(call_floor),
    .location(location), .car_done(car_done), .tick_1s(tick_1s),
    .dest(dest), .dest_valid(dest_valid), .tmr_clr(tmr_clr), .dir_up(dir_up),
    .pending(pending), .fault(fault)
  );

  car_call_scheduler #(.NUM_FLOORS(6), .FLOOR_W(3), .TIMEOUT_S(15)) dut6 (
    .clk(clk), .resetn(resetn), .call_valid(c6_valid), .call_floor(c6_floor),
    .location(loc6), .car_done(done6), .tick_1s(tick6),
    .dest(dest6), .dest_valid(dv6), .tmr_clr(clr6), .dir_up(dir6),
    .pending(pending6), .fault(fault6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = 3'(f);
    step();
    call_valid = 1'b0;
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (dest_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (dest_valid) ok = 1'b1;
  endtask

  // Dispatch check followed by a completed trip at the target floor.
  task automatic serve(input int exp_f, input bit exp_dir, input string nm);
    bit ok;
    wait_dv(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL %s_wait: dest_valid never rose", nm); end
    tests_run++;
    if (dest !== 3'(exp_f)) begin tests_failed++; $display("FAIL %s_dest: got %0d expected %0d", nm, dest, exp_f); end
    tests_run++;
    if (dir_up !== exp_dir) begin tests_failed++; $display("FAIL %s_dir: got %0d expected %0d", nm, dir_up, exp_dir); end
    step();
    location = 3'(exp_f);
    car_done = 1'b1;
    step();
    car_done = 1'b0;
    tests_run++;
    if (dest_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_done: dest_valid got %0d expected 0", nm, dest_valid); end
  endtask

  task automatic check_reset_vals(input string nm);
    tests_run++;
    if ({dest, dest_valid, tmr_clr, dir_up, pending, fault} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s: got dest=%0d dv=%0d clr=%0d dir=%0d pend=%h fault=%0d expected 0 0 0 1 00 0",
               nm, dest, dest_valid, tmr_clr, dir_up, pending, fault);
    end
  endtask

  // SCAN reference: collect pending floors ahead of the car in the sweep
  // direction and take the nearest; otherwise reverse and take the nearest behind.
  task automatic model_pick(input int loc, output int f);
    int q[$];
    f = 0;
    q = {};
    if (m_dir) begin
      for (int i = 0; i < 8; i++) if (m_pend[i] && i >= loc) q.push_back(i);
      if (q.size() > 0) begin q.sort(); f = q[0]; end
      else begin
        m_dir = 1'b0;
        for (int i = 0; i < 8; i++) if (m_pend[i] && i < loc) q.push_back(i);
        q.sort();
        f = q[q.size()-1];
      end
    end else begin
      for (int i = 0; i < 8; i++) if (m_pend[i] && i <= loc) q.push_back(i);
      if (q.size() > 0) begin q.sort(); f = q[q.size()-1]; end
      else begin
        m_dir = 1'b1;
        for (int i = 0; i < 8; i++) if (m_pend[i] && i > loc) q.push_back(i);
        q.sort();
        f = q[0];
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_vals("reset_values");
  endtask

  task automatic test_basic_call();
    location = 3'd0;
    call(5);
    tests_run++;
    if (pending !== 8'h20 || dest_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_capture: pend=%h dv=%0d expected 20 0", pending, dest_valid); end
    step();
    tests_run++;
    if ({dest, dest_valid, tmr_clr} !== {3'd5, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL t1_dispatch: dest=%0d dv=%0d clr=%0d expected 5 1 1", dest, dest_valid, tmr_clr); end
    step();
    tests_run++;
    if ({dest_valid, tmr_clr} !== 2'b10) begin tests_failed++; $display("FAIL t1_travel: dv=%0d clr=%0d expected 1 0", dest_valid, tmr_clr); end
    car_done = 1'b1;
    step();
    car_done = 1'b0;
    tests_run++;
    if ({pending, dest_valid} !== {8'h00, 1'b0}) begin tests_failed++; $display("FAIL t1_done: pend=%h dv=%0d expected 00 0", pending, dest_valid); end
  endtask

  task automatic test_scan_order();
    bit ok;
    location = 3'd3;
    call(3);
    wait_dv(ok);
    step();
    call(1);
    call(6);
    call(4);
    tests_run++;
    if (pending !== 8'h5A) begin tests_failed++; $display("FAIL t2_pending: got %h expected 5a", pending); end
    car_done = 1'b1;
    step();
    car_done = 1'b0;
    serve(4, 1'b1, "t2_first");
    serve(6, 1'b1, "t2_second");
    tests_run++;
    if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL t2_dir_before: got %0d expected 1", dir_up); end
    serve(1, 1'b0, "t2_third");
    tests_run++;
    if (pending !== 8'h00) begin tests_failed++; $display("FAIL t2_empty: got %h expected 00", pending); end
  endtask

  task automatic test_own_floor();
    location = 3'd2;
    call(2);
    serve(2, 1'b0, "t3_own");
    step();
    tests_run++;
    if ({pending[2], dest_valid} !== 2'b00) begin tests_failed++; $display("FAIL t3_idle: pend2=%0d dv=%0d expected 0 0", pending[2], dest_valid); end
  endtask

  task automatic test_set_wins();
    bit ok;
    location = 3'd2;
    call(5);
    wait_dv(ok);
    tests_run++;
    if (!ok || dest !== 3'd5 || dir_up !== 1'b1) begin tests_failed++; $display("FAIL t4_dispatch: ok=%0d dest=%0d dir=%0d expected 1 5 1", ok, dest, dir_up); end
    step();
    call_valid = 1'b1;
    call_floor = 3'd5;
    car_done = 1'b1;
    step();
    call_valid = 1'b0;
    car_done = 1'b0;
    tests_run++;
    if ({pending[5], dest_valid} !== 2'b10) begin tests_failed++; $display("FAIL t4_set_wins: pend5=%0d dv=%0d expected 1 0", pending[5], dest_valid); end
    step();
    tests_run++;
    if ({dest_valid, dest} !== {1'b1, 3'd5}) begin tests_failed++; $display("FAIL t4_redispatch: dv=%0d dest=%0d expected 1 5", dest_valid, dest); end
    step();
    car_done = 1'b1;
    step();
    car_done = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int f;
    int exp_f;
    int ncalls;
    int nticks;
    logic [7:0] exp_vec;
    do_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_dir = 1'b1;
    location = 3'($urandom_range(0, 7));
    for (int trip = 0; trip < 40; trip++) begin
      exp_vec = '0;
      for (int i = 0; i < 8; i++) exp_vec[i] = m_pend[i];
      if (exp_vec == 8'h00) begin
        location = 3'($urandom_range(0, 7));
        f = $urandom_range(0, 7);
        call(f);
        m_pend[f] = 1'b1;
      end
      model_pick(int'(location), exp_f);
      wait_dv(ok);
      tests_run++;
      if (!ok || dest !== 3'(exp_f) || dir_up !== m_dir || tmr_clr !== 1'b1) begin
        tests_failed++;
        $display("FAIL rnd_dispatch[%0d]: ok=%0d dest=%0d dir=%0d clr=%0d expected 1 %0d %0d 1",
                 trip, ok, dest, dir_up, tmr_clr, exp_f, m_dir);
      end
      step();
      ncalls = $urandom_range(0, 3);
      for (int c = 0; c < ncalls; c++) begin
        f = $urandom_range(0, 7);
        call(f);
        m_pend[f] = 1'b1;
      end
      nticks = $urandom_range(0, 3);
      for (int t = 0; t < nticks; t++) begin
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
        step();
      end
      location = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(exp_f);
      car_done = 1'b1;
      step();
      car_done = 1'b0;
      m_pend[exp_f] = 1'b0;
      exp_vec = '0;
      for (int i = 0; i < 8; i++) exp_vec[i] = m_pend[i];
      tests_run++;
      if (pending !== exp_vec || fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL rnd_pending[%0d]: pend=%h fault=%0d expected %h 0", trip, pending, fault, exp_vec);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    location = 3'd0;
    call(7);
    wait_dv(ok);
    tests_run++;
    if (!ok || dest !== 3'd7) begin tests_failed++; $display("FAIL t5_dispatch: ok=%0d dest=%0d expected 1 7", ok, dest); end
    step();
    for (int t = 0; t < 14; t++) begin
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
      step();
    end
    tests_run++;
    if ({fault, dest_valid} !== 2'b01) begin tests_failed++; $display("FAIL t5_14ticks: fault=%0d dv=%0d expected 0 1", fault, dest_valid); end
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
    tests_run++;
    if ({fault, dest_valid} !== 2'b10) begin tests_failed++; $display("FAIL t5_15ticks: fault=%0d dv=%0d expected 1 0", fault, dest_valid); end
    call(2);
    car_done = 1'b1;
    step();
    car_done = 1'b0;
    step();
    tests_run++;
    if ({pending, fault, dest_valid} !== {8'h84, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL t5_sticky: pend=%h fault=%0d dv=%0d expected 84 1 0", pending, fault, dest_valid); end
    resetn = 1'b0;
    #2;
    check_reset_vals("t5_reset");
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_range_and_reset();
    bit ok;
    c6_valid = 1'b1; c6_floor = 3'd7;
    step();
    c6_floor = 3'd6;
    step();
    c6_valid = 1'b0;
    step();
    tests_run++;
    if ({pending6, dv6} !== {6'h00, 1'b0}) begin tests_failed++; $display("FAIL t6_out_of_range: pend=%h dv=%0d expected 00 0", pending6, dv6); end
    c6_valid = 1'b1; c6_floor = 3'd5;
    step();
    c6_valid = 1'b0;
    tests_run++;
    if (pending6 !== 6'h20) begin tests_failed++; $display("FAIL t6_top_floor: pend=%h expected 20", pending6); end
    location = 3'd0;
    call(3);
    wait_dv(ok);
    step();
    call(6);
    tests_run++;
    if ({dest_valid, dest, pending} !== {1'b1, 3'd3, 8'h48}) begin tests_failed++; $display("FAIL t6_travel: dv=%0d dest=%0d pend=%h expected 1 3 48", dest_valid, dest, pending); end
    #3;
    resetn = 1'b0;
    #1;
    check_reset_vals("t6_mid_trip_reset");
    tests_run++;
    if (pending6 !== 6'h00) begin tests_failed++; $display("FAIL t6_reset_small: pend=%h expected 00", pending6); end
    step();
    resetn = 1'b1;
    step();
    step();
    check_reset_vals("t6_after_release");
  endtask

  initial begin
    resetn = 1'b0;
    call_valid = 1'b0; call_floor = '0; location = '0; car_done = 1'b0; tick_1s = 1'b0;
    c6_valid = 1'b0; c6_floor = '0; loc6 = '0; done6 = 1'b0; tick6 = 1'b0;
    test_reset();
    test_basic_call();
    test_scan_order();
    test_own_floor();
    test_set_wins();
    test_random();
    test_timeout();
    test_range_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
